// File: rtl/ppu_mem_responder.sv
// ppu_mem_responder: VRAM/OAM dual-port store serving pipelined PPU reads (port A)
// and locked CPU/DMA accesses (port B), with a fixed read latency on both ports.
module ppu_mem_responder #(
    parameter int RD_LATENCY = 2,
    parameter int VRAM_BYTES = 8192,
    parameter int OAM_BYTES  = 160
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ppu_req_in,
    input  logic [15:0] ppu_addr_in,
    output logic [7:0]  ppu_data_out,
    output logic        ppu_data_valid_out,
    input  logic [1:0]  mode_in,
    input  logic        lcd_en_in,
    input  logic        cpu_re_in,
    input  logic        cpu_we_in,
    input  logic [15:0] cpu_addr_in,
    input  logic [7:0]  cpu_wdata_in,
    output logic [7:0]  cpu_rdata_out,
    output logic        cpu_rvalid_out,
    input  logic        dma_we_in,
    input  logic [7:0]  dma_idx_in,
    input  logic [7:0]  dma_data_in,
    input  logic        dma_active_in
);
    localparam int VA = $clog2(VRAM_BYTES);
    localparam int L  = RD_LATENCY;

    logic [7:0]  vram_q [VRAM_BYTES];
    logic [7:0]  oam_q  [OAM_BYTES];
    // per-stage tag {valid, forced, oam_sel, forced_byte}; data is {oam_byte, vram_byte}
    logic [10:0] pm_q [L];
    logic [10:0] cm_q [L];
    logic [15:0] pd_q [L];
    logic [15:0] cd_q [L];
    logic [7:0]  ph_q, ch_q;
    logic [10:0] pm_d, cm_d;
    logic [1:0]  pk, ck;
    logic        vram_lock, oam_lock, cforce, vram_we, oam_we, dma_ok;
    logic [7:0]  oam_wi, oam_wd;

    // 0 VRAM, 1 OAM, 2 unusable (reads $00), 3 unmapped (reads $FF)
    function automatic logic [1:0] kind(input logic [15:0] a);
        kind = a[15:13] == 3'b100 ? 2'd0 :
               (int'(a) >= 'hFE00 && int'(a) < 'hFE00 + OAM_BYTES) ? 2'd1 :
               a[15:8] == 8'hFE ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [7:0] res(input logic [10:0] m, input logic [15:0] d);
        res = m[9] ? m[7:0] : m[8] ? d[15:8] : d[7:0];
    endfunction

    always_comb begin
        pk        = kind(ppu_addr_in);
        ck        = kind(cpu_addr_in);
        vram_lock = lcd_en_in && mode_in == 2'd3;
        oam_lock  = (lcd_en_in && mode_in[1]) || dma_active_in;
        dma_ok    = dma_we_in && int'(dma_idx_in) < OAM_BYTES;
        cforce    = ck[1] || (ck == 2'd0 && vram_lock) || (ck == 2'd1 && (oam_lock || dma_we_in));
        vram_we   = cpu_we_in && ck == 2'd0 && !vram_lock;
        oam_we    = dma_ok || (cpu_we_in && ck == 2'd1 && !oam_lock && !dma_we_in);
        oam_wi    = dma_ok ? dma_idx_in : cpu_addr_in[7:0];
        oam_wd    = dma_ok ? dma_data_in : cpu_wdata_in;
        pm_d      = {ppu_req_in, pk[1], pk == 2'd1, pk == 2'd2 ? 8'h00 : 8'hFF};
        cm_d      = {cpu_re_in, cforce, ck == 2'd1, ck == 2'd2 ? 8'h00 : 8'hFF};
    end

    always_ff @(posedge clk_in) begin
        if (vram_we) vram_q[cpu_addr_in[VA-1:0]] <= cpu_wdata_in;
        if (oam_we) oam_q[oam_wi] <= oam_wd;
        pd_q[0] <= {oam_q[ppu_addr_in[7:0]], vram_q[ppu_addr_in[VA-1:0]]};
        cd_q[0] <= {oam_q[cpu_addr_in[7:0]], vram_q[cpu_addr_in[VA-1:0]]};
        for (int k = 1; k < L; k++) begin
            pd_q[k] <= pd_q[k-1];
            cd_q[k] <= cd_q[k-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int k = 0; k < L; k++) begin
                pm_q[k] <= '0;
                cm_q[k] <= '0;
            end
            ph_q <= '0;
            ch_q <= '0;
        end else begin
            pm_q[0] <= pm_d;
            cm_q[0] <= cm_d;
            for (int k = 1; k < L; k++) begin
                pm_q[k] <= pm_q[k-1];
                cm_q[k] <= cm_q[k-1];
            end
            ph_q <= ppu_data_out;
            ch_q <= cpu_rdata_out;
        end
    end

    assign ppu_data_valid_out = pm_q[L-1][10];
    assign ppu_data_out       = ppu_data_valid_out ? res(pm_q[L-1], pd_q[L-1]) : ph_q;
    assign cpu_rvalid_out     = cm_q[L-1][10];
    assign cpu_rdata_out      = cpu_rvalid_out ? res(cm_q[L-1], cd_q[L-1]) : ch_q;
endmodule

// File: tb/tb_ppu_mem_responder.sv
// tb_ppu_mem_responder: directed stimulus with a queued scoreboard checked by a
// negedge monitor for data, exact latency, and missing or extra valid pulses.
module tb_ppu_mem_responder;
    localparam int LAT = 2;

    logic        clk = 0, rst_in = 0;
    logic        ppu_req = 0, cpu_re = 0, cpu_we = 0, dma_we = 0, dma_active = 0;
    logic        lcd_en = 1, ppu_valid, cpu_valid;
    logic [1:0]  mode = 0;
    logic [15:0] ppu_addr = 0, cpu_addr = 0;
    logic [7:0]  cpu_wdata = 0, dma_idx = 0, dma_data = 0, ppu_data, cpu_data;
    int          cyc = 0, checks = 0, failures = 0;
    int          pdue[$], cdue[$];
    logic [7:0]  pexp[$], cexp[$];

    ppu_mem_responder #(.RD_LATENCY(LAT)) dut (
        .clk_in(clk), .rst_in(rst_in),
        .ppu_req_in(ppu_req), .ppu_addr_in(ppu_addr),
        .ppu_data_out(ppu_data), .ppu_data_valid_out(ppu_valid),
        .mode_in(mode), .lcd_en_in(lcd_en),
        .cpu_re_in(cpu_re), .cpu_we_in(cpu_we), .cpu_addr_in(cpu_addr),
        .cpu_wdata_in(cpu_wdata), .cpu_rdata_out(cpu_data), .cpu_rvalid_out(cpu_valid),
        .dma_we_in(dma_we), .dma_idx_in(dma_idx), .dma_data_in(dma_data),
        .dma_active_in(dma_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ppu_valid) begin
            if (pexp.size() == 0) chk("ppu_extra_valid", {7'd0, ppu_valid}, 8'd0);
            else begin
                chk("ppu_data", ppu_data, pexp.pop_front());
                chk("ppu_latency", 8'(cyc - pdue.pop_front()), 8'd0);
            end
        end else if (pdue.size() != 0 && pdue[0] < cyc) begin
            chk("ppu_missing_valid", {7'd0, ppu_valid}, 8'd1);
            void'(pdue.pop_front());
            void'(pexp.pop_front());
        end
        if (cpu_valid) begin
            if (cexp.size() == 0) chk("cpu_extra_valid", {7'd0, cpu_valid}, 8'd0);
            else begin
                chk("cpu_data", cpu_data, cexp.pop_front());
                chk("cpu_latency", 8'(cyc - cdue.pop_front()), 8'd0);
            end
        end else if (cdue.size() != 0 && cdue[0] < cyc) begin
            chk("cpu_missing_valid", {7'd0, cpu_valid}, 8'd1);
            void'(cdue.pop_front());
            void'(cexp.pop_front());
        end
    end

    task automatic tick();
        @(negedge clk);
        ppu_req = 0;
        cpu_re  = 0;
        cpu_we  = 0;
        dma_we  = 0;
    endtask

    task automatic pr(input logic [15:0] a, input logic [7:0] e);
        ppu_req  = 1;
        ppu_addr = a;
        pdue.push_back(cyc + LAT);
        pexp.push_back(e);
        tick();
    endtask

    task automatic cr(input logic [15:0] a, input logic [7:0] e);
        cpu_re   = 1;
        cpu_addr = a;
        cdue.push_back(cyc + LAT);
        cexp.push_back(e);
        tick();
    endtask

    task automatic cw(input logic [15:0] a, input logic [7:0] d);
        cpu_we    = 1;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (pdue.size() != 0 || cdue.size() != 0); i++) @(negedge clk);
        chk("queues_drained", 8'(pdue.size() + cdue.size()), 8'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ppu_valid", {7'd0, ppu_valid}, 8'd0);
        chk("rst_ppu_data", ppu_data, 8'h00);
        chk("rst_cpu_valid", {7'd0, cpu_valid}, 8'd0);
        chk("rst_cpu_data", cpu_data, 8'h00);
        rst_in = 1;
        tick();
        cw(16'h8010, 8'hA5);
        pr(16'h8010, 8'hA5);
        cw(16'hFE00, 8'h10);
        cw(16'hFE01, 8'h20);
        cw(16'hFE02, 8'h30);
        cw(16'hFE03, 8'h40);
        pr(16'hFE00, 8'h10);
        pr(16'hFE01, 8'h20);
        pr(16'hFE02, 8'h30);
        pr(16'hFE03, 8'h40);
        drain();
        tick();
        chk("ppu_hold_data", ppu_data, 8'h40);
        chk("ppu_idle_valid", {7'd0, ppu_valid}, 8'd0);
        mode = 2;
        cr(16'hFE00, 8'hFF);
        cw(16'hFE00, 8'h77);
        cr(16'h8010, 8'hA5);
        cr(16'hFE01, 8'hFF);
        mode = 0;
        cr(16'hFE00, 8'h10);
        mode = 3;
        cr(16'h8010, 8'hFF);
        cw(16'h8010, 8'h11);
        pr(16'hFE00, 8'h10);
        pr(16'h8010, 8'hA5);
        mode = 0;
        cr(16'h8010, 8'hA5);
        lcd_en = 0;
        mode = 3;
        cw(16'h9000, 8'h5C);
        cr(16'h9000, 8'h5C);
        lcd_en = 1;
        mode = 0;
        dma_active = 1;
        dma_we = 1; dma_idx = 8'd5; dma_data = 8'hE1;
        cw(16'hFE05, 8'h22);
        dma_we = 1; dma_idx = 8'd7; dma_data = 8'h77;
        cw(16'h8020, 8'h99);
        dma_active = 0;
        cr(16'hFE05, 8'hE1);
        dma_we = 1; dma_idx = 8'd6; dma_data = 8'h66;
        cr(16'hFE06, 8'hFF);
        cr(16'hFE06, 8'h66);
        cr(16'h8020, 8'h99);
        cr(16'hFE07, 8'h77);
        cr(16'hFEA0, 8'h00);
        cr(16'hC000, 8'hFF);
        pr(16'hFEA0, 8'h00);
        pr(16'h0000, 8'hFF);
        cw(16'h8030, 8'h01);
        cpu_we = 1; cpu_wdata = 8'h02;
        cr(16'h8030, 8'h01);
        cr(16'h8030, 8'h02);
        cw(16'h8040, 8'h03);
        cpu_we = 1; cpu_addr = 16'h8040; cpu_wdata = 8'h04;
        pr(16'h8040, 8'h03);
        pr(16'h8040, 8'h04);
        cr(16'h9000, 8'h5C);
        drain();
        ppu_req = 1; ppu_addr = 16'h8010;
        cpu_re = 1; cpu_addr = 16'h9000;
        tick();
        rst_in = 0;
        tick();
        rst_in = 1;
        chk("squash_ppu_valid", {7'd0, ppu_valid}, 8'd0);
        chk("squash_ppu_data", ppu_data, 8'h00);
        chk("squash_cpu_valid", {7'd0, cpu_valid}, 8'd0);
        chk("squash_cpu_data", cpu_data, 8'h00);
        repeat (4) tick();
        pr(16'h8010, 8'hA5);
        cr(16'h9000, 8'h5C);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ppu_mem_responder.md
Name: ppu_mem_responder

Overview:
- Memory-side responder for the pixel processing unit's fetch interface.
- Owns VRAM (8 KiB, $8000-$9FFF) and OAM (160 B, $FE00-$FE9F) as dual-port block RAM:
  - port A serves pipelined PPU reads (addr out, data plus valid pulse back);
  - port B serves CPU reads/writes and OAM DMA writes.
- Enforces DMG access locking from the PPU mode (OAM locked in modes 2/3, VRAM locked in mode 3, OAM locked during DMA).

Parameters:
- RD_LATENCY, 2, cycles from a request being accepted to its valid pulse; legal range 1..4; applies to the PPU and CPU read ports alike.
- VRAM_BYTES, 8192, VRAM depth; must be a power of two.
- OAM_BYTES, 160, OAM depth.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_in  input  1  synchronous, active-low reset.
- ppu_req_in  input  1  PPU read request; one accepted per cycle, no backpressure.
- ppu_addr_in  input  16  PPU read address.
- ppu_data_out  output  8  PPU read data.
- ppu_data_valid_out  output  1  one-cycle pulse per PPU request.
- mode_in  input  2  PPU mode: 0 HBlank, 1 VBlank, 2 OAMScan, 3 Draw.
- lcd_en_in  input  1  LCDC bit 7; when 0, all locking is disabled.
- cpu_re_in  input  1  CPU read strobe.
- cpu_we_in  input  1  CPU write strobe.
- cpu_addr_in  input  16  CPU address.
- cpu_wdata_in  input  8  CPU write data.
- cpu_rdata_out  output  8  CPU read data.
- cpu_rvalid_out  output  1  one-cycle pulse per CPU read.
- dma_we_in  input  1  DMA write strobe into OAM.
- dma_idx_in  input  8  OAM byte index, 0..159.
- dma_data_in  input  8  DMA write data.
- dma_active_in  input  1  DMA transfer in progress.

Behaviour:
- Reset (rst_in=0 at a clock edge): ppu_data_out=0, ppu_data_valid_out=0, cpu_rdata_out=0, cpu_rvalid_out=0. All in-flight pipeline entries are squashed, so no valid pulses fire after reset even for requests issued before it. RAM contents are not cleared.
- Address decode, applied identically on both ports:
  - $8000-$9FFF: VRAM, index = addr[12:0].
  - $FE00-$FE9F: OAM, index = addr-$FE00.
  - $FEA0-$FEFF: unusable; reads return $00, writes are dropped.
  - Anything else: reads return $FF, writes are dropped. A valid pulse is still produced.
- PPU port:
  - ppu_req_in high in cycle N gives ppu_data_valid_out high in cycle N+RD_LATENCY, carrying that request's data.
  - Fully pipelined: back-to-back requests give back-to-back valids, in order.
  - The PPU is never locked out.
  - ppu_data_out holds its last value while valid is low.
- CPU lock:
  - Evaluated from mode_in, lcd_en_in and dma_active_in as sampled in the request cycle.
  - A mode change while a read is in flight does not alter the returned data.
  - OAM is locked when lcd_en_in and mode_in is 2 or 3, or when dma_active_in.
  - VRAM is locked when lcd_en_in and mode_in is 3.
  - A locked read returns $FF with the normal latency. A locked write is dropped.
- CPU reads: cpu_re_in in cycle N gives cpu_rvalid_out in cycle N+RD_LATENCY.
- CPU writes: take effect in RAM at the end of cycle N. A same-address read from either port in cycle N+1 or later returns the new data.
- Same-cycle cpu_re_in and cpu_we_in: the write commits, and the read returns the old data (read-before-write).
- Port B arbitration:
  - dma_we_in has priority over any CPU OAM access in the same cycle; the CPU OAM write is dropped, and a CPU read returns $FF.
  - A dma_idx_in value of 160 or above is ignored.
  - A CPU VRAM access proceeds in parallel with DMA.
- Same-address collision (PPU port A read vs port B write in the same cycle): the PPU receives the old data.
- Latency implementation: a shift register of (valid, forced-value flag, forced byte) per port, aligned with the BRAM output register. Stages beyond the BRAM latency are plain registers.

Test Plan:
- Reset, then CPU writes $A5 to $8010 with mode_in=0; PPU reads $8010 at cycle T gives ppu_data_valid_out exactly at T+2 with ppu_data_out=$A5.
- PPU issues 4 consecutive requests to $FE00-$FE03 preloaded with $10,$20,$30,$40 gives 4 consecutive valids carrying $10,$20,$30,$40 in order, with no gaps.
- mode_in=2, lcd_en_in=1: CPU reads $FE00 and gets $FF; CPU writes $77 to $FE00, then mode_in=0 and a read returns the original value. A VRAM read in mode 2 returns the true data.
- mode_in=3: VRAM read returns $FF and a VRAM write is dropped. With lcd_en_in=0 and mode_in=3, a write of $5C to $9000 succeeds and reads back $5C.
- dma_we_in (idx 5, $E1) and a CPU write to $FE05 with $22 in the same cycle, then dma_active_in=0: OAM[5] reads $E1. Reads of $FEA0 return $00, and reads of $C000 return $FF with cpu_rvalid_out still pulsed.
- PPU request in flight, rst_in=0 for one cycle at T+1: no ppu_data_valid_out pulse at T+2, and outputs are zero. A post-reset read of previously written data returns the preserved value.
